// File: rtl/input_vc_scheduler.sv
// input_vc_scheduler: per-VC packet FSM, downstream VC bookkeeping and round-robin SA nomination.
// Define INPUT_VC_SCHED_LOCK_EN for packet-granular scheduling (a VC keeps the port from first grant to tail).
module input_vc_scheduler #(
    parameter int VC_NUM  = 4,
    parameter int VC_SIZE = 2
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [VC_NUM-1:0]              vc_request_i,
    input  logic [VC_NUM-1:0]              is_empty_i,
    input  logic [VC_NUM-1:0]              vc_valid_i,
    input  logic [VC_NUM-1:0][VC_SIZE-1:0] vc_new_i,
    input  logic [VC_NUM-1:0]              ds_ready_i,
    input  logic [VC_NUM-1:0]              tail_i,
    input  logic                           sa_grant_i,
    output logic                           sa_request_o,
    output logic [VC_SIZE-1:0]             sa_vc_o,
    output logic                           valid_sel_o,
    output logic [VC_SIZE-1:0]             vc_sel_o,
    output logic [VC_SIZE-1:0]             vc_out_o,
    output logic [VC_NUM-1:0]              vc_active_o
);
    localparam logic [1:0] IDLE = 2'd0, WAIT_VA = 2'd1, ACTIVE = 2'd2;
    logic [1:0]         r_state [VC_NUM];
    logic [1:0]         w_next  [VC_NUM];
    logic [VC_SIZE-1:0] r_ds_vc [VC_NUM];
    logic [VC_SIZE-1:0] r_rr_ptr, r_vc_sel, r_vc_out, w_rr_next;
    logic               r_valid_sel, w_take, w_tail;
    logic [VC_NUM-1:0]  w_elig;
    logic [VC_SIZE:0]   w_idx;
`ifdef INPUT_VC_SCHED_LOCK_EN
    logic               r_lock;
    logic [VC_SIZE-1:0] r_lock_vc;
`endif

    assign w_take      = sa_grant_i & sa_request_o;
    assign w_tail      = tail_i[sa_vc_o];
    assign w_rr_next   = (sa_vc_o == VC_SIZE'(VC_NUM - 1)) ? '0 : sa_vc_o + 1'b1;
    assign valid_sel_o = r_valid_sel;
    assign vc_sel_o    = r_vc_sel;
    assign vc_out_o    = r_vc_out;

    always_ff @(posedge clk) begin
        for (int v = 0; v < VC_NUM; v++) begin
            if (!rst) begin
                r_state[v] <= IDLE;
                r_ds_vc[v] <= '0;
            end else begin
                r_state[v] <= w_next[v];
                if (r_state[v] == WAIT_VA && vc_valid_i[v]) r_ds_vc[v] <= vc_new_i[v];
            end
        end
    end

    always_comb begin
        for (int v = 0; v < VC_NUM; v++) begin
            w_next[v] = (r_state[v] == IDLE)    ? ((vc_request_i[v] & ~is_empty_i[v]) ? WAIT_VA : IDLE) :
                        (r_state[v] == WAIT_VA) ? (vc_valid_i[v] ? ACTIVE : WAIT_VA) :
                        (w_take && w_tail && sa_vc_o == VC_SIZE'(v)) ? IDLE : r_state[v];
        end
    end

    // A VC read last cycle is masked because its is_empty_i has not caught up yet.
    always_comb begin
        sa_request_o = 1'b0;
        sa_vc_o      = '0;
        w_idx        = '0;
        w_elig       = '0;
        vc_active_o  = '0;
        for (int v = 0; v < VC_NUM; v++) begin
            vc_active_o[v] = r_state[v] == ACTIVE;
            w_elig[v] = (r_state[v] == ACTIVE) & ~is_empty_i[v] & ds_ready_i[v]
                      & ~(r_valid_sel & (r_vc_sel == VC_SIZE'(v)))
`ifdef INPUT_VC_SCHED_LOCK_EN
                      & (~r_lock | (r_lock_vc == VC_SIZE'(v)))
`endif
                      ;
        end
        for (int i = 0; i < VC_NUM; i++) begin
            w_idx = {1'b0, r_rr_ptr} + (VC_SIZE+1)'(i);
            w_idx = (w_idx >= (VC_SIZE+1)'(VC_NUM)) ? w_idx - (VC_SIZE+1)'(VC_NUM) : w_idx;
            if (!sa_request_o && w_elig[w_idx[VC_SIZE-1:0]]) begin
                sa_request_o = 1'b1;
                sa_vc_o      = w_idx[VC_SIZE-1:0];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_rr_ptr    <= '0;
            r_valid_sel <= 1'b0;
            r_vc_sel    <= '0;
            r_vc_out    <= '0;
`ifdef INPUT_VC_SCHED_LOCK_EN
            r_lock      <= 1'b0;
            r_lock_vc   <= '0;
`endif
        end else begin
            r_valid_sel <= w_take;
            r_vc_sel    <= w_take ? sa_vc_o : '0;
            r_vc_out    <= w_take ? r_ds_vc[sa_vc_o] : '0;
`ifdef INPUT_VC_SCHED_LOCK_EN
            if (w_take) begin
                r_lock    <= ~w_tail;
                r_lock_vc <= sa_vc_o;
                if (w_tail) r_rr_ptr <= w_rr_next;
            end
`else
            if (w_take) r_rr_ptr <= w_rr_next;
`endif
        end
    end
endmodule

// File: tb/tb_input_vc_scheduler.sv
// tb_input_vc_scheduler: directed table, randomized run against a behavioural model, and corner-case sequences.
module tb_input_vc_scheduler;
    localparam int N = 4, S = 2;
    logic clk = 1'b0, rst = 1'b0;
    logic [N-1:0] vc_request, is_empty, vc_valid, ds_ready, tail;
    logic [N-1:0][S-1:0] vc_new;
    logic sa_grant, sa_request, valid_sel;
    logic [S-1:0] sa_vc, vc_sel, vc_out;
    logic [N-1:0] vc_active;
    int checks = 0, errors = 0;

    input_vc_scheduler #(.VC_NUM(N), .VC_SIZE(S)) dut (
        .clk(clk), .rst(rst), .vc_request_i(vc_request), .is_empty_i(is_empty),
        .vc_valid_i(vc_valid), .vc_new_i(vc_new), .ds_ready_i(ds_ready), .tail_i(tail),
        .sa_grant_i(sa_grant), .sa_request_o(sa_request), .sa_vc_o(sa_vc),
        .valid_sel_o(valid_sel), .vc_sel_o(vc_sel), .vc_out_o(vc_out), .vc_active_o(vc_active)
    );

    always #5 clk = ~clk;

    task automatic chk(string name, int act, int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    // Behavioural model: packet phase per VC (0 idle, 1 awaiting VA, 2 holding downstream VC).
    int m_st[N], m_ds[N];
    int m_rr = 0, m_lv = 0, m_lvc = 0, m_lout = 0;
`ifdef INPUT_VC_SCHED_LOCK_EN
    int m_lk = 0, m_lkvc = 0;
`endif

    function automatic bit elig(int v);
        return m_st[v] == 2 && !is_empty[v] && ds_ready[v] && !(m_lv != 0 && m_lvc == v)
`ifdef INPUT_VC_SCHED_LOCK_EN
            && (m_lk == 0 || m_lkvc == v)
`endif
            ;
    endfunction

    task automatic step(bit do_chk);
        bit r, take;
        int vc;
        @(negedge clk);
        r = 0;
        vc = 0;
        for (int i = 0; i < N; i++)
            if (!r && elig((m_rr + i) % N)) begin
                r = 1;
                vc = (m_rr + i) % N;
            end
        if (do_chk) begin
            chk("sa_request", int'(sa_request), int'(r));
            if (r) chk("sa_vc", int'(sa_vc), vc);
            chk("valid_sel", int'(valid_sel), m_lv);
            if (m_lv != 0) begin
                chk("vc_sel", int'(vc_sel), m_lvc);
                chk("vc_out", int'(vc_out), m_lout);
            end
            for (int v = 0; v < N; v++) chk("vc_active", int'(vc_active[v]), int'(m_st[v] == 2));
        end
        if (!rst) begin
            for (int v = 0; v < N; v++) begin
                m_st[v] = 0;
                m_ds[v] = 0;
            end
            m_rr = 0; m_lv = 0; m_lvc = 0; m_lout = 0;
`ifdef INPUT_VC_SCHED_LOCK_EN
            m_lk = 0; m_lkvc = 0;
`endif
        end else begin
            take = sa_grant && r;
            m_lout = take ? m_ds[vc] : 0;
            for (int v = 0; v < N; v++) begin
                if (m_st[v] == 0) begin
                    if (vc_request[v] && !is_empty[v]) m_st[v] = 1;
                end else if (m_st[v] == 1) begin
                    if (vc_valid[v]) begin
                        m_st[v] = 2;
                        m_ds[v] = int'(vc_new[v]);
                    end
                end else if (take && vc == v && tail[v]) m_st[v] = 0;
            end
            m_lv = int'(take);
            m_lvc = take ? vc : 0;
`ifdef INPUT_VC_SCHED_LOCK_EN
            if (take) begin
                if (tail[vc]) begin
                    m_rr = (vc + 1) % N;
                    m_lk = 0;
                end else begin
                    m_lk = 1;
                    m_lkvc = vc;
                end
            end
`else
            if (take) m_rr = (vc + 1) % N;
`endif
        end
        @(posedge clk);
        #1;
    endtask

    task automatic set_idle();
        rst = 1'b1; vc_request = '0; is_empty = '1; vc_valid = '0;
        vc_new = '0; ds_ready = '1; tail = '0; sa_grant = 1'b0;
    endtask

    typedef struct {
        logic rst; logic [3:0] req, emp, vld; logic [7:0] vnew; logic [3:0] rdy, tl;
        logic gnt, chk_en, sel_chk, e_req; logic [1:0] e_savc; logic e_vs;
        logic [1:0] e_vsel, e_vout; logic [3:0] e_act;
    } vec_t;
    vec_t tbl[13];

    initial begin
        int rr_seq[6], ds_seq[6], cnt[N];
        int order[$];
        tbl[0]  = '{1'b0, 4'hF, 4'hF, 4'hF, 8'hFF, 4'hF, 4'hF, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 2'd0, 2'd0, 4'h0};
        tbl[1]  = '{1'b0, 4'hF, 4'hF, 4'hF, 8'hFF, 4'hF, 4'hF, 1'b1, 1'b1, 1'b1, 1'b0, 2'd0, 1'b0, 2'd0, 2'd0, 4'h0};
        tbl[2]  = '{1'b1, 4'h4, 4'hB, 4'h0, 8'h00, 4'hF, 4'h0, 1'b0, 1'b1, 1'b1, 1'b0, 2'd0, 1'b0, 2'd0, 2'd0, 4'h0};
        tbl[3]  = '{1'b1, 4'h4, 4'hB, 4'h4, 8'h30, 4'hF, 4'h0, 1'b0, 1'b1, 1'b1, 1'b0, 2'd0, 1'b0, 2'd0, 2'd0, 4'h0};
        tbl[4]  = '{1'b1, 4'h0, 4'hB, 4'h0, 8'h00, 4'hF, 4'h0, 1'b1, 1'b1, 1'b0, 1'b1, 2'd2, 1'b0, 2'd0, 2'd0, 4'h4};
        tbl[5]  = '{1'b1, 4'h0, 4'hB, 4'h0, 8'h00, 4'hF, 4'h0, 1'b1, 1'b1, 1'b0, 1'b0, 2'd0, 1'b1, 2'd2, 2'd3, 4'h4};
        tbl[6]  = '{1'b1, 4'h0, 4'hB, 4'h0, 8'h00, 4'hF, 4'h0, 1'b1, 1'b1, 1'b0, 1'b1, 2'd2, 1'b0, 2'd0, 2'd0, 4'h4};
        tbl[7]  = '{1'b1, 4'h0, 4'hB, 4'h0, 8'h00, 4'hF, 4'h0, 1'b1, 1'b1, 1'b0, 1'b0, 2'd0, 1'b1, 2'd2, 2'd3, 4'h4};
        tbl[8]  = '{1'b1, 4'h0, 4'hB, 4'h0, 8'h00, 4'hF, 4'h0, 1'b1, 1'b1, 1'b0, 1'b1, 2'd2, 1'b0, 2'd0, 2'd0, 4'h4};
        tbl[9]  = '{1'b1, 4'h0, 4'hB, 4'h0, 8'h00, 4'hF, 4'h0, 1'b1, 1'b1, 1'b0, 1'b0, 2'd0, 1'b1, 2'd2, 2'd3, 4'h4};
        tbl[10] = '{1'b1, 4'h0, 4'hB, 4'h0, 8'h00, 4'hF, 4'h4, 1'b1, 1'b1, 1'b0, 1'b1, 2'd2, 1'b0, 2'd0, 2'd0, 4'h4};
        tbl[11] = '{1'b1, 4'h0, 4'hB, 4'h0, 8'h00, 4'hF, 4'h0, 1'b1, 1'b1, 1'b0, 1'b0, 2'd0, 1'b1, 2'd2, 2'd3, 4'h0};
        tbl[12] = '{1'b1, 4'h0, 4'hF, 4'h0, 8'h00, 4'hF, 4'h0, 1'b1, 1'b1, 1'b0, 1'b0, 2'd0, 1'b0, 2'd0, 2'd0, 4'h0};
        @(posedge clk);
        #1;
        for (int i = 0; i < 13; i++) begin
            rst = tbl[i].rst; vc_request = tbl[i].req; is_empty = tbl[i].emp; vc_valid = tbl[i].vld;
            vc_new = tbl[i].vnew; ds_ready = tbl[i].rdy; tail = tbl[i].tl; sa_grant = tbl[i].gnt;
            @(negedge clk);
            if (tbl[i].chk_en) begin
                chk($sformatf("t%0d_sa_request", i), int'(sa_request), int'(tbl[i].e_req));
                if (tbl[i].sel_chk || tbl[i].e_req) chk($sformatf("t%0d_sa_vc", i), int'(sa_vc), int'(tbl[i].e_savc));
                chk($sformatf("t%0d_valid_sel", i), int'(valid_sel), int'(tbl[i].e_vs));
                if (tbl[i].sel_chk || tbl[i].e_vs) begin
                    chk($sformatf("t%0d_vc_sel", i), int'(vc_sel), int'(tbl[i].e_vsel));
                    chk($sformatf("t%0d_vc_out", i), int'(vc_out), int'(tbl[i].e_vout));
                end
                chk($sformatf("t%0d_vc_active", i), int'(vc_active), int'(tbl[i].e_act));
            end
            @(posedge clk);
            #1;
        end

        set_idle();
        rst = 1'b0;
        step(1'b0);
        for (int k = 0; k < 3000; k++) begin
            rst = $urandom_range(0, 99) != 0;
            vc_request = 4'($urandom);
            is_empty = 4'($urandom) & 4'($urandom);
            vc_valid = 4'($urandom);
            vc_new = 8'($urandom);
            ds_ready = ~(4'($urandom) & 4'($urandom) & 4'($urandom));
            tail = 4'($urandom) & 4'($urandom);
            sa_grant = $urandom_range(0, 3) != 0;
            step(1'b1);
        end

`ifndef INPUT_VC_SCHED_LOCK_EN
        rr_seq = '{0, 1, 3, 0, 1, 3};
        ds_seq = '{1, 2, 3, 1, 2, 3};
        set_idle(); rst = 1'b0; step(1'b1); step(1'b1); rst = 1'b1;
        vc_request = 4'b1011; is_empty = 4'b0100; step(1'b1);
        vc_request = '0; vc_valid = 4'b1011; vc_new = 8'b11_00_10_01; step(1'b1);
        vc_valid = '0; sa_grant = 1'b1;
        for (int k = 0; k < 6; k++) begin
            step(1'b1);
            chk("rr_valid", int'(valid_sel), 1);
            chk("rr_order", int'(vc_sel), rr_seq[k]);
            chk("rr_vc_out", int'(vc_out), ds_seq[k]);
        end
        ds_ready = 4'b1101;
        for (int k = 0; k < 5; k++) begin
            #3;
            chk("bp_masked", int'(sa_request && sa_vc == 2'd1), 0);
            step(1'b1);
        end
        ds_ready = '1; is_empty = 4'b1101;
        #3;
        chk("bp_rise_req", int'(sa_request), 1);
        chk("bp_rise_vc", int'(sa_vc), 1);
        step(1'b1);
`endif

        set_idle(); rst = 1'b0; step(1'b1); step(1'b1); rst = 1'b1;
        vc_request = 4'b0001; is_empty = 4'b1110; step(1'b1);
        vc_request = '0; vc_valid = 4'b0001; vc_new = 8'h01; step(1'b1);
        vc_new = 8'h02; step(1'b1);
        vc_valid = '0; sa_grant = 1'b1; tail = 4'b0001; vc_request = 4'b0001; step(1'b1);
        chk("tail_idle", int'(vc_active[0]), 0);
        chk("tail_read", int'(valid_sel), 1);
        chk("ds_kept", int'(vc_out), 1);
        sa_grant = 1'b0; tail = '0; vc_valid = 4'b0001; vc_new = 8'h02; step(1'b1);
        chk("idle_no_va", int'(vc_active[0]), 0);
        vc_request = '0; vc_new = 8'h03; step(1'b1);
        chk("wait_to_active", int'(vc_active[0]), 1);
        vc_valid = '0; sa_grant = 1'b1; step(1'b1);
        chk("new_ds_read", int'(valid_sel), 1);
        chk("new_ds_out", int'(vc_out), 3);

`ifdef INPUT_VC_SCHED_LOCK_EN
        set_idle(); rst = 1'b0; step(1'b1); step(1'b1); rst = 1'b1;
        vc_request = 4'b0011; is_empty = 4'b1100; step(1'b1);
        vc_request = '0; vc_valid = 4'b0011; vc_new = 8'b00_00_10_01; step(1'b1);
        vc_valid = '0; sa_grant = 1'b1;
        for (int v = 0; v < N; v++) cnt[v] = 0;
        for (int k = 0; k < 14; k++) begin
            for (int v = 0; v < N; v++) tail[v] = cnt[v] == 2;
            step(1'b1);
            if (valid_sel) begin
                cnt[vc_sel]++;
                order.push_back(int'(vc_sel));
            end
        end
        chk("lock_reads", int'(order.size() >= 4), 1);
        if (order.size() >= 4) begin
            for (int j = 0; j < 3; j++) chk("lock_vc0_first", order[j], 0);
            chk("lock_vc1_after", order[3], 1);
        end
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/input_vc_scheduler.md
# input_vc_scheduler

Per-input-port scheduler between `input_port`, the VC allocator and the switch allocator. It tracks a per-VC packet state machine, records the downstream VC granted by VA, and nominates one eligible local VC per cycle to the switch allocator, using round-robin among VCs. On a switch grant it drives the input port's read select (`valid_sel`/`vc_sel`) and the downstream VC id, and it releases the VC on the tail flit.

## Interface
Parameters:
- `VC_NUM`, `noc_params::VC_NUM`, number of local virtual channels.
- `VC_SIZE`, `noc_params::VC_SIZE`, VC id width.

Ports:
- `clk` in 1: single clock; all state updates on its rising edge.
- `rst` in 1: reset, synchronous, active-low.
- `vc_request_i` in VC_NUM: head flit at front of VC v requests VA (from `input_port.vc_request_o`).
- `is_empty_i` in VC_NUM: VC v buffer empty.
- `vc_valid_i` in VC_NUM: VA grant for VC v this cycle.
- `vc_new_i` in VC_NUM x VC_SIZE: downstream VC granted to VC v; valid with `vc_valid_i[v]`.
- `ds_ready_i` in VC_NUM: downstream on/off for the VC allocated to local VC v (already muxed); 1 = may send.
- `tail_i` in VC_NUM: front flit of VC v is TAIL or HEADTAIL.
- `sa_grant_i` in 1: switch allocator grants this port's current nomination.
- `sa_request_o` out 1: nomination valid.
- `sa_vc_o` out VC_SIZE: nominated local VC.
- `valid_sel_o` out 1: read one flit from `vc_sel_o` (to `input_port.valid_sel_i`).
- `vc_sel_o` out VC_SIZE: local VC to read.
- `vc_out_o` out VC_SIZE: downstream VC id for the flit read this cycle.
- `vc_active_o` out VC_NUM: VC v holds a downstream VC (state ACTIVE).

## Operation
- Per-VC FSM, states IDLE, WAIT_VA, ACTIVE:
  - IDLE -> WAIT_VA when `vc_request_i[v] & ~is_empty_i[v]`.
  - WAIT_VA -> ACTIVE on `vc_valid_i[v]`; latch `vc_new_i[v]` into `ds_vc[v]`.
  - ACTIVE -> IDLE when a grant is taken for v with `tail_i[v]=1`.
  - `vc_valid_i[v]` in IDLE or ACTIVE is ignored.
- A VC is eligible when all of: ACTIVE, `~is_empty_i[v]`, `ds_ready_i[v]`, and v was not read in the previous cycle (`valid_sel_o & vc_sel_o==v`). The last condition prevents a double read against a stale `is_empty_i`.
- Nomination is combinational from registered state. It selects the first eligible VC searching upward from `rr_ptr`, wrapping modulo VC_NUM. `sa_request_o=0` when no VC is eligible.
- Grant is taken when `sa_grant_i & sa_request_o`. On a grant to v:
  - `rr_ptr <= (v+1) mod VC_NUM`.
  - Next cycle: `valid_sel_o=1`, `vc_sel_o=v`, `vc_out_o=ds_vc[v]`, for exactly one cycle.
- `sa_grant_i` while `sa_request_o=0` is ignored.
- Tail grant plus a new head: when a tail grant for v coincides with `vc_request_i[v]` for the next packet, v goes IDLE in that cycle and may enter WAIT_VA the following cycle. No state is skipped.

## Timing
- Reset (`rst=0` at an edge): all FSMs IDLE, `rr_ptr=0`, `ds_vc=0`, `valid_sel_o=0`, `vc_sel_o=0`, `vc_out_o=0`, `vc_active_o=0`, `sa_request_o=0`, `sa_vc_o=0`.
- Reset mid-packet discards all state; upstream reset is coherent.
- VA grant at edge t -> `vc_active_o[v]=1` from t; earliest `sa_request_o` for v in cycle t.
- Grant sampled at edge t -> read select valid in cycle t..t+1 (registered, one-cycle latency).
- Throughput: a single VC is nominated at most every other cycle. With two or more eligible VCs, the port can be granted every cycle.
- `ds_ready_i` dropping masks v in the same cycle (combinational eligibility).

## Configuration
- `INPUT_VC_SCHED_LOCK_EN` defined: packet-granular scheduling.
  - After the first grant to an ACTIVE VC v, only v may be nominated until its tail grant.
  - The lock holds even if v is temporarily ineligible; no other VC is nominated meanwhile.
  - `rr_ptr` advances only on the tail grant.
- Not defined: flit-granular round-robin as described above; no lock register.

## Test plan
- Reset: drive `rst=0` for 2 cycles with all inputs active -> every output 0; after release, VC2 with head, `vc_valid_i[2]=1`, `vc_new_i[2]=3` -> `vc_active_o=0b0100`, then `sa_vc_o=2`.
- Single-VC 4-flit packet, `sa_grant_i` held 1 -> `valid_sel_o` pattern 1,0,1,0…, `vc_sel_o=2`, `vc_out_o=3` on each read. After the read with `tail_i[2]=1`, `vc_active_o[2]=0`.
- VC0, VC1 and VC3 all ACTIVE and non-empty, grant held -> reads 0,1,3,0,1,3 on consecutive cycles (lock off). Pointer wraps from 3 to 0.
- Backpressure: `ds_ready_i[1]=0` for 5 cycles -> VC1 never nominated in that window. When it rises, VC1 is nominated in the same cycle.
- Tail plus new head: tail grant for VC0 with `vc_request_i[0]=1` -> VC0 IDLE for one cycle, WAIT_VA next; a `vc_valid_i[0]` pulse while ACTIVE is ignored (`ds_vc[0]` unchanged).
- With `INPUT_VC_SCHED_LOCK_EN`: VC0 and VC1 both ACTIVE with 3-flit packets -> all three VC0 reads complete before any VC1 read.
